cave_input_ctrl: RTL

//   Parametrised player-input front end for the cave core, feeding Main's io_joystick_* ports.

---
 rtl/cave_input_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/cave_input_ctrl.sv
// cave_input_ctrl: player-input front end for the cave core.
// Merges hps_io PS/2 keys with MiSTer joysticks, shapes coin and autofire.
module cave_input_ctrl #(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_BUTTONS       = 3,
  parameter int COIN_PULSE_CYCLES = 16,
  parameter int AUTOFIRE_DIV      = 20
) (
  input  logic                               clk_sys,
  input  logic                               RESET,
  input  logic [10:0]                        ps2_key,
  input  logic [32*NUM_PLAYERS-1:0]          joystick,
  input  logic                               autofire_en,
  input  logic [NUM_BUTTONS-1:0]             autofire_mask,
  output logic [NUM_PLAYERS-1:0]             up,
  output logic [NUM_PLAYERS-1:0]             down,
  output logic [NUM_PLAYERS-1:0]             left,
  output logic [NUM_PLAYERS-1:0]             right,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PLAYERS-1:0]             start,
  output logic [NUM_PLAYERS-1:0]             coin,
  output logic [NUM_PLAYERS-1:0]             pause,
  output logic [NUM_PLAYERS-1:0]             service
);

  localparam int NP = NUM_PLAYERS;
  localparam int NB = NUM_BUTTONS;
  localparam int CP = COIN_PULSE_CYCLES;
  localparam int CW = (CP > 0) ? $clog2(CP + 1) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(CP);

  // Key register layout mirrors the joystick word for 3 buttons
  localparam int K_RIGHT = 0;
  localparam int K_LEFT  = 1;
  localparam int K_DOWN  = 2;
  localparam int K_UP    = 3;
  localparam int K_BTN   = 4;
  localparam int K_START = 7;
  localparam int K_COIN  = 8;
  localparam int K_PAUSE = 9;
  localparam int K_SERV  = 10;

  logic             primed_q, primed_d;
  logic             old_toggle_q, old_toggle_d;
  logic [1:0][10:0] key_q, key_d;
  logic             ps2_evt;
  logic             pressed;

  always_comb begin
    primed_d     = 1'b1;
    key_d        = key_q;
    pressed      = ps2_key[9];
    ps2_evt      = primed_q && (ps2_key[10] != old_toggle_q);
    old_toggle_d = old_toggle_q;
    if (!primed_q || ps2_evt)
      old_toggle_d = ps2_key[10];
    if (ps2_evt) begin
      case (ps2_key[7:0])
        8'h75: key_d[0][K_UP]      = pressed;
        8'h72: key_d[0][K_DOWN]    = pressed;
        8'h6B: key_d[0][K_LEFT]    = pressed;
        8'h74: key_d[0][K_RIGHT]   = pressed;
        8'h14: key_d[0][K_BTN]     = pressed;
        8'h11: key_d[0][K_BTN+1]   = pressed;
        8'h29: key_d[0][K_BTN+2]   = pressed;
        8'h16: key_d[0][K_START]   = pressed;
        8'h2E: key_d[0][K_COIN]    = pressed;
        8'h4D: key_d[0][K_PAUSE]   = pressed;
        8'h46: key_d[0][K_SERV]    = pressed;
        8'h2D: key_d[1][K_UP]      = pressed;
        8'h2B: key_d[1][K_DOWN]    = pressed;
        8'h23: key_d[1][K_LEFT]    = pressed;
        8'h34: key_d[1][K_RIGHT]   = pressed;
        8'h1C: key_d[1][K_BTN]     = pressed;
        8'h1B: key_d[1][K_BTN+1]   = pressed;
        8'h15: key_d[1][K_BTN+2]   = pressed;
        8'h1E: key_d[1][K_START]   = pressed;
        8'h36: key_d[1][K_COIN]    = pressed;
        8'h45: key_d[1][K_SERV]    = pressed;
        default: ;
      endcase
    end
  end

  logic unused_misc;
  assign unused_misc = ^{ps2_key[8], key_q};

  logic [NP-1:0]    m_up, m_down, m_left, m_right;
  logic [NP-1:0]    m_start, m_coin, m_pause, m_serv;
  logic [NP*NB-1:0] m_btn;

  for (genvar p = 0; p < NP; p++) begin : g_pl
    logic [10:0] kp;
    logic [31:0] js;
    logic        unused_js;

    // Only players 0 and 1 have keyboard bindings
    if (p < 2) begin : g_kb
      assign kp = key_q[p];
    end else begin : g_nokb
      assign kp = '0;
    end

    assign js        = joystick[32*p +: 32];
    assign unused_js = ^{js, kp};

    assign m_right[p] = js[0] | kp[K_RIGHT];
    assign m_left[p]  = js[1] | kp[K_LEFT];
    assign m_down[p]  = js[2] | kp[K_DOWN];
    assign m_up[p]    = js[3] | kp[K_UP];
    assign m_start[p] = js[4+NB] | kp[K_START];
    assign m_coin[p]  = js[5+NB] | kp[K_COIN];
    assign m_pause[p] = js[6+NB] | kp[K_PAUSE];
    assign m_serv[p]  = js[7+NB] | kp[K_SERV];

    for (genvar k = 0; k < NB; k++) begin : g_btn
      if (k < 3) begin : g_kbtn
        assign m_btn[p*NB+k] = js[4+k] | kp[K_BTN+k];
      end else begin : g_jbtn
        assign m_btn[p*NB+k] = js[4+k];
      end
    end
  end

  logic [NP-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NP-1:0]         coin_prev_q, coin_prev_d;
  logic [NP-1:0]         coin_q, coin_d;
  logic [NP-1:0]         rise;

  always_comb begin
    coin_prev_d = m_coin;
    cnt_d       = cnt_q;
    coin_d      = '0;
    rise        = m_coin & ~coin_prev_q;
    for (int p = 0; p < NP; p++) begin
      if (CP == 0) begin
        coin_d[p] = m_coin[p];
      end else begin
        // Edges arriving mid-pulse are dropped, never queued
        if (rise[p] && cnt_q[p] == '0)
          cnt_d[p] = COIN_LOAD;
        else if (cnt_q[p] != '0)
          cnt_d[p] = cnt_q[p] - CW'(1);
        coin_d[p] = (cnt_d[p] != '0);
      end
    end
  end

  logic [AUTOFIRE_DIV-1:0] af_cnt_q, af_cnt_d;
  logic                    phase_q, phase_d;

  always_comb begin
    af_cnt_d = af_cnt_q + AUTOFIRE_DIV'(1);
    phase_d  = phase_q ^ (&af_cnt_q);
  end

  logic [NP-1:0]    up_q, up_d, down_q, down_d;
  logic [NP-1:0]    left_q, left_d, right_q, right_d;
  logic [NP-1:0]    start_q, start_d, pause_q, pause_d;
  logic [NP-1:0]    serv_q, serv_d;
  logic [NP*NB-1:0] btn_q, btn_d;

  always_comb begin
    up_d    = m_up;
    down_d  = m_down;
    left_d  = m_left;
    right_d = m_right;
    start_d = m_start;
    pause_d = m_pause;
    serv_d  = m_serv;
    btn_d   = '0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < NB; k++) begin
        btn_d[p*NB+k] = m_btn[p*NB+k] &
          (~autofire_en | ~autofire_mask[k] | phase_q);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      primed_q     <= 1'b0;
      old_toggle_q <= 1'b0;
      key_q        <= '0;
      cnt_q        <= '0;
      coin_prev_q  <= '0;
      coin_q       <= '0;
      af_cnt_q     <= '0;
      phase_q      <= 1'b0;
      up_q         <= '0;
      down_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      start_q      <= '0;
      pause_q      <= '0;
      serv_q       <= '0;
      btn_q        <= '0;
    end else begin
      primed_q     <= primed_d;
      old_toggle_q <= old_toggle_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      coin_prev_q  <= coin_prev_d;
      coin_q       <= coin_d;
      af_cnt_q     <= af_cnt_d;
      phase_q      <= phase_d;
      up_q         <= up_d;
      down_q       <= down_d;
      left_q       <= left_d;
      right_q      <= right_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
      serv_q       <= serv_d;
      btn_q        <= btn_d;
    end
  end

  assign up      = up_q;
  assign down    = down_q;
  assign left    = left_q;
  assign right   = right_q;
  assign buttons = btn_q;
  assign start   = start_q;
  assign coin    = coin_q;
  assign pause   = pause_q;
  assign service = serv_q;

endmodule
